// File: rtl/fwrisc_regfile_pkg.sv
// fwrisc_regfile_pkg
//   Shared definitions for the fwrisc register file with scoreboard.
//   - addr_width(): address width derived from the number of entries.
//   - CSR_* : CSR-space addresses of the 64-bit cycle/instret counter halves.
//   - CNT_W / CNT_HALF_W: counter width and width of one addressable half.
//   - rd_sel_e: source of a registered read result (zero, RAM, bypass/counter).
package fwrisc_regfile_pkg;

  localparam int CNT_W      = 64;
  localparam int CNT_HALF_W = CNT_W / 2;

  localparam int CSR_CYCLE    = 'h3C;
  localparam int CSR_CYCLEH   = 'h3D;
  localparam int CSR_INSTRET  = 'h3E;
  localparam int CSR_INSTRETH = 'h3F;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_MEM  = 2'd1,
    SEL_ALT  = 2'd2
  } rd_sel_e;

  function automatic int addr_width(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/fwrisc_regfile_counters.sv
// fwrisc_regfile_counters
//   64-bit cycle and instret counters, each addressable as two 32-bit halves
//   in CSR space, with one read mux per read port.
// Ports
//   clock, reset     clock; asynchronous active-low reset (counters -> 0)
//   wen/waddr/wdata  writeback; a write to a counter half loads that half
//   instr_complete   one pulse per retired instruction
//   raddr            per-port read addresses, port p in [p*AW +: AW]
//   rdata            per-port pre-edge counter value (combinational)
//   hit              per-port: address selects a counter half
module fwrisc_regfile_counters
  import fwrisc_regfile_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int AW           = 6,
  parameter int NUM_RD_PORTS = 2,
  parameter int ENABLE       = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wen,
  input  logic [AW-1:0]                waddr,
  input  logic [XLEN-1:0]              wdata,
  input  logic                         instr_complete,
  input  logic [NUM_RD_PORTS*AW-1:0]   raddr,
  output logic [NUM_RD_PORTS*XLEN-1:0] rdata,
  output logic [NUM_RD_PORTS-1:0]      hit
);

  localparam logic [AW-1:0] A_CYCLE    = AW'(CSR_CYCLE);
  localparam logic [AW-1:0] A_CYCLEH   = AW'(CSR_CYCLEH);
  localparam logic [AW-1:0] A_INSTRET  = AW'(CSR_INSTRET);
  localparam logic [AW-1:0] A_INSTRETH = AW'(CSR_INSTRETH);

  logic [CNT_W-1:0]      cycle_q, cycle_d;
  logic [CNT_W-1:0]      instret_q, instret_d;
  logic [CNT_HALF_W-1:0] whalf;
  logic                  load_en;

  assign whalf   = CNT_HALF_W'(wdata);
  assign load_en = (ENABLE != 0) && wen;

  // A load replaces the increment for that counter entirely in that cycle:
  // the untouched half holds its value and no carry crosses halves.
  always_comb begin
    cycle_d   = cycle_q + CNT_W'(1);
    instret_d = instret_q + CNT_W'(instr_complete);
    if (load_en) begin
      case (waddr)
        A_CYCLE:    cycle_d   = {cycle_q[CNT_W-1:CNT_HALF_W], whalf};
        A_CYCLEH:   cycle_d   = {whalf, cycle_q[CNT_HALF_W-1:0]};
        A_INSTRET:  instret_d = {instret_q[CNT_W-1:CNT_HALF_W], whalf};
        A_INSTRETH: instret_d = {whalf, instret_q[CNT_HALF_W-1:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
      logic [AW-1:0]         ra;
      logic [CNT_HALF_W-1:0] half;
      logic                  is_cnt;

      assign ra = raddr[gi*AW +: AW];

      always_comb begin
        half   = '0;
        is_cnt = 1'b0;
        if (ENABLE != 0) begin
          is_cnt = 1'b1;
          case (ra)
            A_CYCLE:    half = cycle_q[CNT_HALF_W-1:0];
            A_CYCLEH:   half = cycle_q[CNT_W-1:CNT_HALF_W];
            A_INSTRET:  half = instret_q[CNT_HALF_W-1:0];
            A_INSTRETH: half = instret_q[CNT_W-1:CNT_HALF_W];
            default:    is_cnt = 1'b0;
          endcase
        end
      end

      assign rdata[gi*XLEN +: XLEN] = XLEN'(half);
      assign hit[gi]                = is_cnt;
    end
  endgenerate

endmodule

// File: rtl/fwrisc_regfile_sb.sv
// fwrisc_regfile_sb
//   Register file (GPRs 0-31, CSR space above) with N registered read ports,
//   optional write-to-read bypass, a per-register busy scoreboard and
//   optional cycle/instret counters mapped into CSR space.
// Ports
//   clock, reset     clock; asynchronous active-low reset
//   rd_raddr         read addresses, port p in [p*AW +: AW]
//   rd_rdata         read data (1-cycle latency), port p in [p*XLEN +: XLEN]
//   rd_busy          per port: address had a pending write when sampled
//   issue_valid/issue_waddr/issue_ready  decode marks a destination busy
//   wb_wen/wb_waddr/wb_wdata             writeback; clears busy
//   instr_complete   retire pulse for instret
//   flush            clears every busy bit
module fwrisc_regfile_sb
  import fwrisc_regfile_pkg::*;
#(
  parameter int NREGS           = 64,
  parameter int XLEN            = 32,
  parameter int NUM_RD_PORTS    = 2,
  parameter int ENABLE_BYPASS   = 1,
  parameter int ENABLE_COUNTERS = 1,
  localparam int AW             = addr_width(NREGS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_RD_PORTS*AW-1:0]   rd_raddr,
  output logic [NUM_RD_PORTS*XLEN-1:0] rd_rdata,
  output logic [NUM_RD_PORTS-1:0]      rd_busy,
  input  logic                         issue_valid,
  input  logic [AW-1:0]                issue_waddr,
  output logic                         issue_ready,
  input  logic                         wb_wen,
  input  logic [AW-1:0]                wb_waddr,
  input  logic [XLEN-1:0]              wb_wdata,
  input  logic                         instr_complete,
  input  logic                         flush
);

  logic                         wb_active;
  logic [NREGS-1:0]             busy_q, busy_d;
  logic [NUM_RD_PORTS*XLEN-1:0] cnt_rdata;
  logic [NUM_RD_PORTS-1:0]      cnt_hit;

  // Address 0 has no storage, so a write there is a no-op everywhere.
  assign wb_active = wb_wen && (wb_waddr != '0);

  // ---------------- scoreboard ----------------
  assign issue_ready = !busy_q[issue_waddr]
                     || (wb_wen && (wb_waddr == issue_waddr))
                     || (issue_waddr == '0);

  // Clear first, then set: an issue and a writeback to the same register in
  // one cycle leave it busy because the newly issued writer is still pending.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wb_active) busy_d[wb_waddr] = 1'b0;
      if (issue_valid && issue_ready && (issue_waddr != '0)) busy_d[issue_waddr] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // ---------------- counters ----------------
  fwrisc_regfile_counters #(
    .XLEN         (XLEN),
    .AW           (AW),
    .NUM_RD_PORTS (NUM_RD_PORTS),
    .ENABLE       (ENABLE_COUNTERS)
  ) u_counters (
    .clock          (clock),
    .reset          (reset),
    .wen            (wb_wen),
    .waddr          (wb_waddr),
    .wdata          (wb_wdata),
    .instr_complete (instr_complete),
    .raddr          (rd_raddr),
    .rdata          (cnt_rdata),
    .hit            (cnt_hit)
  );

  // ---------------- read ports ----------------
  // Each port owns a RAM copy (same writes, private read address) so every
  // port maps onto a single-read-port block RAM. The RAM output register has
  // no reset; a small reset-able select flop picks zero / RAM / alternate data
  // so the outputs still drop to 0 as soon as reset asserts.
  generate
    for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
      logic [XLEN-1:0] mem [NREGS];
      logic [XLEN-1:0] mem_rdata_q;
      logic [AW-1:0]   ra;
      logic            byp_hit;
      rd_sel_e         sel_q, sel_d;
      logic [XLEN-1:0] alt_q, alt_d;
      logic            busy_rd_q, busy_rd_d;
      logic [XLEN-1:0] rdata_p;

      assign ra      = rd_raddr[gi*AW +: AW];
      assign byp_hit = (ENABLE_BYPASS != 0) && wb_wen && (wb_waddr == ra);

      // Read-before-write RAM: without bypass a same-cycle write is not seen.
      always_ff @(posedge clock) begin
        if (wb_active) mem[wb_waddr] <= wb_wdata;
        mem_rdata_q <= mem[ra];
      end

      // Bypass outranks the counter mux so a loaded counter half is forwarded.
      always_comb begin
        sel_d     = SEL_MEM;
        alt_d     = cnt_rdata[gi*XLEN +: XLEN];
        busy_rd_d = busy_q[ra] && !(wb_wen && (wb_waddr == ra));
        if (ra == '0) begin
          sel_d = SEL_ZERO;
        end else if (byp_hit) begin
          sel_d = SEL_ALT;
          alt_d = wb_wdata;
        end else if (cnt_hit[gi]) begin
          sel_d = SEL_ALT;
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          sel_q     <= SEL_ZERO;
          alt_q     <= '0;
          busy_rd_q <= 1'b0;
        end else begin
          sel_q     <= sel_d;
          alt_q     <= alt_d;
          busy_rd_q <= busy_rd_d;
        end
      end

      always_comb begin
        rdata_p = '0;
        case (sel_q)
          SEL_MEM: rdata_p = mem_rdata_q;
          SEL_ALT: rdata_p = alt_q;
          default: rdata_p = '0;
        endcase
      end

      assign rd_rdata[gi*XLEN +: XLEN] = rdata_p;
      assign rd_busy[gi]               = busy_rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_fwrisc_regfile_sb.sv
// Directed bench for fwrisc_regfile_sb. Two instances share all inputs:
// dut (bypass + counters enabled) and dut_nb (bypass and counters disabled).
module tb_fwrisc_regfile_sb;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] rd_raddr;
  logic [63:0] rd_rdata, rd_rdata_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        issue_valid;
  logic [5:0]  issue_waddr;
  logic        issue_ready, issue_ready_nb;
  logic        wb_wen;
  logic [5:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        instr_complete;
  logic        flush;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  fwrisc_regfile_sb dut (
    .clock(clock), .reset(reset), .rd_raddr(rd_raddr), .rd_rdata(rd_rdata),
    .rd_busy(rd_busy), .issue_valid(issue_valid), .issue_waddr(issue_waddr),
    .issue_ready(issue_ready), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .instr_complete(instr_complete), .flush(flush)
  );

  fwrisc_regfile_sb #(.ENABLE_BYPASS(0), .ENABLE_COUNTERS(0)) dut_nb (
    .clock(clock), .reset(reset), .rd_raddr(rd_raddr), .rd_rdata(rd_rdata_nb),
    .rd_busy(rd_busy_nb), .issue_valid(issue_valid), .issue_waddr(issue_waddr),
    .issue_ready(issue_ready_nb), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .instr_complete(instr_complete), .flush(flush)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-22s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ra(input logic [5:0] p0, input logic [5:0] p1);
    rd_raddr = {p1, p0};
  endtask

  task automatic wb(input logic en, input logic [5:0] a, input logic [31:0] d);
    wb_wen   = en;
    wb_waddr = a;
    wb_wdata = d;
  endtask

  initial begin
    reset = 1'b0; rd_raddr = '0; issue_valid = 1'b0; issue_waddr = '0;
    wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0; instr_complete = 1'b0; flush = 1'b0;

    // Reset state
    #1;
    check("reset_rdata", rd_rdata, 64'h0);
    check("reset_busy", {62'd0, rd_busy}, 64'h0);
    check("reset_ready", {63'd0, issue_ready}, 64'h1);
    step(); step();
    reset = 1'b1;
    step();

    // Write x5, read next cycle
    wb(1'b1, 6'd5, 32'hDEADBEEF); set_ra(6'd0, 6'd0);
    step();
    wb(1'b0, 6'd0, 32'h0); set_ra(6'd5, 6'd0);
    step();
    check("x5_read", {32'd0, rd_rdata[31:0]}, 64'hDEADBEEF);
    check("x5_read_nb", {32'd0, rd_rdata_nb[31:0]}, 64'hDEADBEEF);

    // Write to x0 is ignored
    wb(1'b1, 6'd0, 32'h1); set_ra(6'd0, 6'd0);
    step();
    wb(1'b0, 6'd0, 32'h0);
    step();
    check("x0_reads_zero", {32'd0, rd_rdata[31:0]}, 64'h0);

    // Bypass: same-cycle write and read of x7 on port 1
    wb(1'b1, 6'd7, 32'h1111);
    step();
    wb(1'b1, 6'd7, 32'h1234); set_ra(6'd0, 6'd7);
    step();
    check("bypass_on", {32'd0, rd_rdata[63:32]}, 64'h1234);
    check("bypass_off_old", {32'd0, rd_rdata_nb[63:32]}, 64'h1111);
    wb(1'b0, 6'd0, 32'h0);
    step();
    check("x7_after_write_nb", {32'd0, rd_rdata_nb[63:32]}, 64'h1234);

    // Scoreboard: issue x3, re-issue blocked, read busy, wb clears
    issue_valid = 1'b1; issue_waddr = 6'd3;
    #1;
    check("x3_ready_first", {63'd0, issue_ready}, 64'h1);
    step();
    check("x3_ready_second", {63'd0, issue_ready}, 64'h0);
    issue_valid = 1'b0; set_ra(6'd3, 6'd0);
    step();
    check("x3_rd_busy", {62'd0, rd_busy}, 64'h1);
    wb(1'b1, 6'd3, 32'h33);
    #1;
    check("x3_ready_during_wb", {63'd0, issue_ready}, 64'h1);
    step();
    check("x3_busy_bypassed", {62'd0, rd_busy}, 64'h0);
    check("x3_bypass_data", {32'd0, rd_rdata[31:0]}, 64'h33);
    wb(1'b0, 6'd0, 32'h0);
    #1;
    check("x3_ready_after_wb", {63'd0, issue_ready}, 64'h1);

    // Issue and writeback to x9 in the same cycle: stays busy
    issue_valid = 1'b1; issue_waddr = 6'd9; wb(1'b1, 6'd9, 32'h99);
    step();
    issue_valid = 1'b0; wb(1'b0, 6'd0, 32'h0); set_ra(6'd0, 6'd9);
    #1;
    check("x9_still_busy_ready", {63'd0, issue_ready}, 64'h0);
    step();
    check("x9_rd_busy", {62'd0, rd_busy}, 64'h2);
    check("x9_data", {32'd0, rd_rdata[63:32]}, 64'h99);

    // Flush overrides a same-cycle issue of x4
    flush = 1'b1; issue_valid = 1'b1; issue_waddr = 6'd4;
    step();
    flush = 1'b0; issue_valid = 1'b0;
    #1;
    check("flush_x4_ready", {63'd0, issue_ready}, 64'h1);
    issue_waddr = 6'd9;
    #1;
    check("flush_x9_ready", {63'd0, issue_ready}, 64'h1);
    set_ra(6'd4, 6'd9);
    step();
    check("flush_rd_busy", {62'd0, rd_busy}, 64'h0);

    // Cycle counter: load high=0, then low=FFFFFFFF; low wraps and carries
    wb(1'b1, 6'h3D, 32'h0);
    step();
    wb(1'b1, 6'h3C, 32'hFFFFFFFF);
    step();
    wb(1'b0, 6'd0, 32'h0); set_ra(6'h3D, 6'h3C);
    step();
    check("cycle_pre_carry", rd_rdata, 64'hFFFFFFFF_00000000);
    check("csr_plain_nb", rd_rdata_nb, 64'hFFFFFFFF_00000000);
    step();
    check("cycle_carry", rd_rdata, 64'h00000000_00000001);

    // Instret: three retire pulses
    instr_complete = 1'b1;
    step(); step(); step();
    instr_complete = 1'b0; set_ra(6'h3E, 6'h3F);
    step();
    check("instret_3", rd_rdata, 64'h00000000_00000003);

    // Load wins over increment; loaded half is bypassed to the same-cycle read
    wb(1'b1, 6'h3E, 32'd100); instr_complete = 1'b1;
    step();
    check("instret_load_bypass", {32'd0, rd_rdata[31:0]}, 64'd100);
    wb(1'b0, 6'd0, 32'h0); instr_complete = 1'b0;
    step();
    check("instret_load_wins", {32'd0, rd_rdata[31:0]}, 64'd100);

    // Reset mid-run with x12 busy
    issue_valid = 1'b1; issue_waddr = 6'd12;
    step();
    issue_valid = 1'b0; set_ra(6'd12, 6'd5);
    step();
    check("x12_busy_pre_reset", {62'd0, rd_busy}, 64'h1);
    check("x5_pre_reset", {32'd0, rd_rdata[63:32]}, 64'hDEADBEEF);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_rdata", rd_rdata, 64'h0);
    check("async_reset_busy", {62'd0, rd_busy}, 64'h0);
    step();
    reset = 1'b1;
    step();
    check("post_reset_ready", {63'd0, issue_ready}, 64'h1);
    check("post_reset_rd_busy", {62'd0, rd_busy}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
